// File: rtl/control_pkg.sv
// Shared definitions for the multi-cycle control unit: opcodes, ALU/memory
// operation codes, FSM states and the datapath control bundle.
package control_pkg;

  localparam int ALU_OP_W    = 4;
  localparam int MEM_OP_W    = 2;
  localparam int NUM_OPCODES = 16;

  localparam logic [3:0] OP_ADD  = 4'd0;
  localparam logic [3:0] OP_ADDI = 4'd1;
  localparam logic [3:0] OP_SUB  = 4'd2;
  localparam logic [3:0] OP_SUBI = 4'd3;
  localparam logic [3:0] OP_NOT  = 4'd4;
  localparam logic [3:0] OP_AND  = 4'd5;
  localparam logic [3:0] OP_OR   = 4'd6;
  localparam logic [3:0] OP_NAND = 4'd7;
  localparam logic [3:0] OP_NOR  = 4'd8;
  localparam logic [3:0] OP_MOV  = 4'd9;
  localparam logic [3:0] OP_LI   = 4'd10;
  localparam logic [3:0] OP_LW   = 4'd11;
  localparam logic [3:0] OP_SW   = 4'd12;
  localparam logic [3:0] OP_BEQ  = 4'd13;
  localparam logic [3:0] OP_BNE  = 4'd14;
  localparam logic [3:0] OP_JUMP = 4'd15;

  localparam logic [ALU_OP_W-1:0] ALU_OP_ADD  = 4'd0;
  localparam logic [ALU_OP_W-1:0] ALU_OP_SUB  = 4'd1;
  localparam logic [ALU_OP_W-1:0] ALU_OP_NOT  = 4'd2;
  localparam logic [ALU_OP_W-1:0] ALU_OP_AND  = 4'd3;
  localparam logic [ALU_OP_W-1:0] ALU_OP_OR   = 4'd4;
  localparam logic [ALU_OP_W-1:0] ALU_OP_NAND = 4'd5;
  localparam logic [ALU_OP_W-1:0] ALU_OP_NOR  = 4'd6;
  localparam logic [ALU_OP_W-1:0] ALU_OP_MOV  = 4'd7;
  localparam logic [ALU_OP_W-1:0] ALU_OP_LI   = 4'd8;

  localparam logic [MEM_OP_W-1:0] MEM_OP_NOP   = 2'd0;
  localparam logic [MEM_OP_W-1:0] MEM_OP_READ  = 2'd1;
  localparam logic [MEM_OP_W-1:0] MEM_OP_WRITE = 2'd2;

  typedef enum logic [2:0] {
    IDLE, FETCH, DECODE, EXEC, MEM, WB, HALT
  } state_t;

  typedef struct packed {
    logic                reg_dst;
    logic                alu_src;
    logic [ALU_OP_W-1:0] alu_op;
    logic                mem_to_reg;
    logic                is_mem;
    logic                is_branch;
    logic                is_jump;
    logic                illegal;
  } decode_t;

  typedef struct packed {
    logic                imem_req;
    logic                ir_write;
    logic                pc_inc;
    logic                pc_load;
    logic                reg_dst;
    logic                alu_src;
    logic                mem_to_reg;
    logic                reg_write;
    logic                beq;
    logic                bne;
    logic                address_src;
    logic [ALU_OP_W-1:0] alu_op;
    logic [MEM_OP_W-1:0] mem_op;
    logic                instr_done;
  } ctrl_t;

  function automatic logic opcode_illegal(input logic [31:0] op);
    return op >= 32'(NUM_OPCODES);
  endfunction

endpackage

// File: rtl/control_decode.sv
// Combinational opcode decoder: maps the latched opcode to its static datapath
// controls and instruction class. The FSM decides when these are driven.
module control_decode
  import control_pkg::*;
#(
  parameter int OP_CODE_BITS = 6
) (
  input  logic [OP_CODE_BITS-1:0] op,
  output decode_t                 dec
);

  logic [31:0] op_ext;

  assign op_ext = 32'(op);

  always_comb begin
    dec         = '0;
    dec.alu_op  = ALU_OP_ADD;
    dec.illegal = opcode_illegal(op_ext);
    if (!dec.illegal) begin
      case (op_ext[3:0])
        OP_ADD:  dec.reg_dst = 1'b1;
        OP_ADDI: dec.alu_src = 1'b1;
        OP_SUB:  begin dec.reg_dst = 1'b1; dec.alu_op = ALU_OP_SUB;  end
        OP_SUBI: begin dec.alu_src = 1'b1; dec.alu_op = ALU_OP_SUB;  end
        OP_NOT:  begin dec.reg_dst = 1'b1; dec.alu_op = ALU_OP_NOT;  end
        OP_AND:  begin dec.reg_dst = 1'b1; dec.alu_op = ALU_OP_AND;  end
        OP_OR:   begin dec.reg_dst = 1'b1; dec.alu_op = ALU_OP_OR;   end
        OP_NAND: begin dec.reg_dst = 1'b1; dec.alu_op = ALU_OP_NAND; end
        OP_NOR:  begin dec.reg_dst = 1'b1; dec.alu_op = ALU_OP_NOR;  end
        OP_MOV:  begin dec.reg_dst = 1'b1; dec.alu_op = ALU_OP_MOV;  end
        OP_LI:   begin dec.alu_src = 1'b1; dec.alu_op = ALU_OP_LI;   end
        // Loads and stores use the ALU for base + offset addressing.
        OP_LW: begin
          dec.alu_src    = 1'b1;
          dec.mem_to_reg = 1'b1;
          dec.is_mem     = 1'b1;
        end
        OP_SW: begin
          dec.alu_src = 1'b1;
          dec.is_mem  = 1'b1;
        end
        OP_BEQ, OP_BNE: begin
          dec.alu_op    = ALU_OP_SUB;
          dec.is_branch = 1'b1;
        end
        OP_JUMP: dec.is_jump = 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/multicycle_control_unit.sv
// Multi-cycle control FSM: sequences fetch/decode/execute/memory/writeback with
// ready handshakes, resolves branches, and halts on illegal opcode or timeout.
module multicycle_control_unit
  import control_pkg::*;
#(
  parameter int OP_CODE_BITS = 6,
  parameter int ALU_OP_BITS  = 4,
  parameter int MEM_OP_BITS  = 2,
  parameter int MEM_TIMEOUT  = 15
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    enable,
  input  logic [OP_CODE_BITS-1:0] opcode,
  input  logic                    imem_ready,
  input  logic                    dmem_ready,
  input  logic                    alu_zero,
  output logic                    imem_req,
  output logic                    ir_write,
  output logic                    pc_inc,
  output logic                    pc_load,
  output logic                    reg_dst,
  output logic                    alu_src,
  output logic                    mem_to_reg,
  output logic                    reg_write,
  output logic                    beq,
  output logic                    bne,
  output logic                    address_src,
  output logic [ALU_OP_BITS-1:0]  alu_op,
  output logic [MEM_OP_BITS-1:0]  mem_op,
  output logic                    instr_done,
  output logic                    illegal_op,
  output logic                    mem_fault,
  output logic                    halted
);

  state_t                  state_reg, state_next;
  logic [OP_CODE_BITS-1:0] op_q, op_q_next;
  logic [7:0]              wait_cnt_reg, wait_cnt_next, wait_inc;
  logic                    illegal_reg, illegal_next;
  logic                    mem_fault_reg, mem_fault_next;
  logic                    timeout;
  logic                    op_is_beq;
  decode_t                 dec;
  ctrl_t                   ctrl;

  control_decode #(.OP_CODE_BITS(OP_CODE_BITS)) u_decode (
    .op  (op_q),
    .dec (dec)
  );

  // Saturating wait count; a ready in the cycle the count would reach the
  // limit still wins, because the ready branches are tested first below.
  assign wait_inc  = (wait_cnt_reg == 8'hFF) ? 8'hFF : wait_cnt_reg + 8'd1;
  assign timeout   = (wait_inc >= 8'(MEM_TIMEOUT));
  assign op_is_beq = (32'(op_q) == 32'(OP_BEQ));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= IDLE;
      op_q          <= '0;
      wait_cnt_reg  <= '0;
      illegal_reg   <= 1'b0;
      mem_fault_reg <= 1'b0;
    end else begin
      state_reg     <= state_next;
      op_q          <= op_q_next;
      wait_cnt_reg  <= wait_cnt_next;
      illegal_reg   <= illegal_next;
      mem_fault_reg <= mem_fault_next;
    end
  end

  always_comb begin
    state_next     = state_reg;
    op_q_next      = op_q;
    wait_cnt_next  = wait_cnt_reg;
    illegal_next   = illegal_reg;
    mem_fault_next = mem_fault_reg;
    case (state_reg)
      IDLE: if (enable) state_next = FETCH;
      FETCH: begin
        if (imem_ready) begin
          state_next = DECODE;
        end else if (timeout) begin
          mem_fault_next = 1'b1;
          state_next     = HALT;
        end else begin
          wait_cnt_next = wait_inc;
        end
      end
      DECODE: begin
        op_q_next = opcode;
        if (opcode_illegal(32'(opcode))) begin
          illegal_next = 1'b1;
          state_next   = HALT;
        end else begin
          state_next = EXEC;
        end
      end
      EXEC: begin
        if (dec.illegal) begin
          illegal_next = 1'b1;
          state_next   = HALT;
        end else if (dec.is_mem) begin
          state_next = MEM;
        end else if (dec.is_branch || dec.is_jump) begin
          state_next = FETCH;
        end else begin
          state_next = WB;
        end
      end
      MEM: begin
        if (dmem_ready) begin
          state_next = dec.mem_to_reg ? WB : FETCH;
        end else if (timeout) begin
          mem_fault_next = 1'b1;
          state_next     = HALT;
        end else begin
          wait_cnt_next = wait_inc;
        end
      end
      WB:      state_next = FETCH;
      HALT:    state_next = HALT;
      default: state_next = IDLE;
    endcase
    // Every entry into a waiting state starts from a fresh count.
    if (state_next != state_reg) wait_cnt_next = '0;
  end

  always_comb begin
    ctrl        = '0;
    ctrl.alu_op = ALU_OP_ADD;
    ctrl.mem_op = MEM_OP_NOP;
    case (state_reg)
      FETCH: begin
        ctrl.imem_req = 1'b1;
        ctrl.ir_write = imem_ready;
        ctrl.pc_inc   = imem_ready;
      end
      EXEC: begin
        ctrl.reg_dst = dec.reg_dst;
        ctrl.alu_src = dec.alu_src;
        ctrl.alu_op  = dec.alu_op;
        if (dec.is_branch) begin
          ctrl.beq        = op_is_beq;
          ctrl.bne        = !op_is_beq;
          ctrl.pc_load    = op_is_beq ? alu_zero : !alu_zero;
          ctrl.instr_done = 1'b1;
        end
        if (dec.is_jump) begin
          ctrl.address_src = 1'b1;
          ctrl.pc_load     = 1'b1;
          ctrl.instr_done  = 1'b1;
        end
      end
      MEM: begin
        ctrl.reg_dst    = dec.reg_dst;
        ctrl.alu_src    = dec.alu_src;
        ctrl.alu_op     = dec.alu_op;
        ctrl.mem_op     = dec.mem_to_reg ? MEM_OP_READ : MEM_OP_WRITE;
        ctrl.instr_done = dmem_ready && !dec.mem_to_reg;
      end
      WB: begin
        ctrl.reg_dst    = dec.reg_dst;
        ctrl.alu_src    = dec.alu_src;
        ctrl.alu_op     = dec.alu_op;
        ctrl.mem_to_reg = dec.mem_to_reg;
        ctrl.reg_write  = 1'b1;
        ctrl.instr_done = 1'b1;
      end
      default: ;
    endcase
  end

  assign imem_req    = ctrl.imem_req;
  assign ir_write    = ctrl.ir_write;
  assign pc_inc      = ctrl.pc_inc;
  assign pc_load     = ctrl.pc_load;
  assign reg_dst     = ctrl.reg_dst;
  assign alu_src     = ctrl.alu_src;
  assign mem_to_reg  = ctrl.mem_to_reg;
  assign reg_write   = ctrl.reg_write;
  assign beq         = ctrl.beq;
  assign bne         = ctrl.bne;
  assign address_src = ctrl.address_src;
  assign alu_op      = ALU_OP_BITS'(ctrl.alu_op);
  assign mem_op      = MEM_OP_BITS'(ctrl.mem_op);
  assign instr_done  = ctrl.instr_done;
  assign illegal_op  = illegal_reg;
  assign mem_fault   = mem_fault_reg;
  assign halted      = illegal_reg | mem_fault_reg;

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Scoreboard bench: stimulus pushes an expected per-instruction summary, a
// monitor builds the observed summary and compares on retire or halt.
module tb_multicycle_control_unit;
  import control_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       enable = 1'b0;
  logic [5:0] opcode = '0;
  logic       imem_ready = 1'b0;
  logic       dmem_ready = 1'b0;
  logic       alu_zero = 1'b0;
  logic       imem_req, ir_write, pc_inc, pc_load, reg_dst, alu_src;
  logic       mem_to_reg, reg_write, beq, bne, address_src;
  logic [3:0] alu_op;
  logic [1:0] mem_op;
  logic       instr_done, illegal_op, mem_fault, halted;

  multicycle_control_unit #(
    .OP_CODE_BITS(6), .ALU_OP_BITS(4), .MEM_OP_BITS(2), .MEM_TIMEOUT(15)
  ) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .opcode(opcode),
    .imem_ready(imem_ready), .dmem_ready(dmem_ready), .alu_zero(alu_zero),
    .imem_req(imem_req), .ir_write(ir_write), .pc_inc(pc_inc), .pc_load(pc_load),
    .reg_dst(reg_dst), .alu_src(alu_src), .mem_to_reg(mem_to_reg),
    .reg_write(reg_write), .beq(beq), .bne(bne), .address_src(address_src),
    .alu_op(alu_op), .mem_op(mem_op), .instr_done(instr_done),
    .illegal_op(illegal_op), .mem_fault(mem_fault), .halted(halted)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit halt;
    int cycles;
    int ir_cyc;
    bit rw;
    bit mtr;
    bit rdst;
    int aop;
    bit pcl;
    int rd;
    int wr;
    bit ill;
    bit mf;
    bit ovl;
  } rec_t;

  rec_t exp_q[$];
  int   total = 0;
  int   bad = 0;
  int   imem_delay = 0;
  int   dmem_delay = 0;
  bit   toggle_mode = 1'b0;

  // monitor state
  bit   mon_active = 1'b0;
  bit   mon_hprev = 1'b0;
  int   mon_cyc = 0;
  int   mon_n = 0;
  rec_t mon_obs;
  rec_t mon_exp;

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic rec_t retire(input int cycles, input int ir_cyc, input bit rw,
                                  input bit mtr, input bit rdst, input int aop,
                                  input bit pcl, input int rd, input int wr);
    rec_t r;
    r = '{default: 0};
    r.cycles = cycles; r.ir_cyc = ir_cyc; r.rw = rw; r.mtr = mtr; r.rdst = rdst;
    r.aop = aop; r.pcl = pcl; r.rd = rd; r.wr = wr;
    return r;
  endfunction

  function automatic rec_t halt_rec(input int cycles, input int ir_cyc, input bit ill, input bit mf);
    rec_t r;
    r = '{default: 0};
    r.halt = 1'b1; r.cycles = cycles; r.ir_cyc = ir_cyc; r.ill = ill; r.mf = mf;
    return r;
  endfunction

  task automatic compare_rec(input int n, input rec_t o, input rec_t e);
    string p;
    p = $sformatf("txn%0d_", n);
    check({p, "halt"},        o.halt,   e.halt);
    check({p, "cycles"},      o.cycles, e.cycles);
    check({p, "ir_write_cyc"},o.ir_cyc, e.ir_cyc);
    check({p, "reg_write"},   o.rw,     e.rw);
    check({p, "mem_to_reg"},  o.mtr,    e.mtr);
    check({p, "reg_dst"},     o.rdst,   e.rdst);
    check({p, "alu_op"},      o.aop,    e.aop);
    check({p, "pc_load"},     o.pcl,    e.pcl);
    check({p, "read_cycles"}, o.rd,     e.rd);
    check({p, "write_cycles"},o.wr,     e.wr);
    check({p, "illegal_op"},  o.ill,    e.ill);
    check({p, "mem_fault"},   o.mf,     e.mf);
    check({p, "inc_load_overlap"}, o.ovl, e.ovl);
  endtask

  // Monitor: accumulate what the DUT drives over one instruction.
  initial begin
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        mon_active = 1'b0;
        mon_hprev  = 1'b0;
      end else begin
        if (!mon_active && imem_req) begin
          mon_active = 1'b1;
          mon_cyc    = 0;
          mon_obs    = '{default: 0};
        end
        if (mon_active) begin
          mon_cyc++;
          if (ir_write && mon_obs.ir_cyc == 0) mon_obs.ir_cyc = mon_cyc;
          if (reg_write) begin
            mon_obs.rw   = 1'b1;
            mon_obs.mtr  = mem_to_reg;
            mon_obs.rdst = reg_dst;
            mon_obs.aop  = int'(alu_op);
          end
          if (pc_load) mon_obs.pcl = 1'b1;
          if (mem_op == MEM_OP_READ) mon_obs.rd++;
          if (mem_op == MEM_OP_WRITE) mon_obs.wr++;
          if (pc_inc && pc_load) mon_obs.ovl = 1'b1;
          if (instr_done || (halted && !mon_hprev)) begin
            mon_obs.halt   = halted;
            mon_obs.cycles = mon_cyc;
            mon_obs.ill    = illegal_op;
            mon_obs.mf     = mem_fault;
            mon_n++;
            $display("txn %0d: opcode=%0d cycles=%0d halted=%0d", mon_n, opcode, mon_cyc, halted);
            if (exp_q.size() == 0) begin
              check($sformatf("txn%0d_unexpected", mon_n), 1, 0);
            end else begin
              mon_exp = exp_q.pop_front();
              compare_rec(mon_n, mon_obs, mon_exp);
            end
            mon_active = 1'b0;
          end
        end
        mon_hprev = halted;
      end
    end
  end

  // Memory responder: ready after the configured number of wait cycles.
  initial begin
    int i_cnt;
    int d_cnt;
    i_cnt = 0;
    d_cnt = 0;
    forever begin
      @(posedge clk);
      #1;
      if (toggle_mode) begin
        imem_ready = 1'($urandom_range(0, 1));
        dmem_ready = 1'($urandom_range(0, 1));
      end else begin
        if (imem_req) begin
          imem_ready = (i_cnt == imem_delay);
          i_cnt++;
        end else begin
          imem_ready = 1'b0;
          i_cnt = 0;
        end
        if (mem_op != MEM_OP_NOP) begin
          dmem_ready = (d_cnt == dmem_delay);
          d_cnt++;
        end else begin
          dmem_ready = 1'b0;
          d_cnt = 0;
        end
      end
    end
  end

  task automatic issue(input int op, input int idly, input int ddly, input bit zero, input rec_t e);
    opcode     = 6'(op);
    imem_delay = idly;
    dmem_delay = ddly;
    alu_zero   = zero;
    exp_q.push_back(e);
  endtask

  task automatic wait_end(input string name, input int limit);
    int k;
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (!(instr_done || halted) && k < limit);
    check({name, "_ended"}, int'(instr_done || halted), 1);
    #1;
  endtask

  initial begin
    #3;
    check("rst_imem_req", imem_req, 0);
    check("rst_mem_op", mem_op, MEM_OP_NOP);
    check("rst_alu_op", alu_op, ALU_OP_ADD);
    check("rst_halted", halted, 0);
    check("rst_instr_done", instr_done, 0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;

    issue(0, 0, 0, 0, retire(4, 1, 1, 0, 1, ALU_OP_ADD, 0, 0, 0));
    enable = 1'b1;
    wait_end("add", 50);
    issue(11, 0, 3, 0, retire(8, 1, 1, 1, 0, ALU_OP_ADD, 0, 4, 0));
    wait_end("lw_wait3", 50);
    issue(13, 0, 0, 1, retire(3, 1, 0, 0, 0, 0, 1, 0, 0));
    wait_end("beq_taken", 50);
    issue(13, 0, 0, 0, retire(3, 1, 0, 0, 0, 0, 0, 0, 0));
    wait_end("beq_not_taken", 50);
    issue(14, 0, 0, 0, retire(3, 1, 0, 0, 0, 0, 1, 0, 0));
    wait_end("bne_taken", 50);
    issue(14, 0, 0, 1, retire(3, 1, 0, 0, 0, 0, 0, 0, 0));
    wait_end("bne_not_taken", 50);
    issue(15, 0, 0, 0, retire(3, 1, 0, 0, 0, 0, 1, 0, 0));
    wait_end("jump", 50);
    issue(12, 0, 0, 0, retire(4, 1, 0, 0, 0, 0, 0, 0, 1));
    wait_end("sw", 50);
    issue(2, 0, 0, 0, retire(4, 1, 1, 0, 1, ALU_OP_SUB, 0, 0, 0));
    wait_end("sub", 50);
    issue(1, 2, 0, 0, retire(6, 3, 1, 0, 0, ALU_OP_ADD, 0, 0, 0));
    wait_end("addi_fetch_wait2", 50);
    issue(8, 0, 0, 0, retire(4, 1, 1, 0, 1, ALU_OP_NOR, 0, 0, 0));
    wait_end("nor", 50);
    issue(0, 14, 0, 0, retire(18, 15, 1, 0, 1, ALU_OP_ADD, 0, 0, 0));
    wait_end("add_ready_cycle15", 60);
    issue(12, 0, 14, 0, retire(18, 1, 0, 0, 0, 0, 0, 0, 15));
    wait_end("sw_ready_cycle15", 60);
    issue(20, 0, 0, 0, halt_rec(3, 1, 1, 0));
    wait_end("illegal", 50);

    toggle_mode = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      check($sformatf("halt_hold%0d_halted", i), halted, 1);
      check($sformatf("halt_hold%0d_reg_write", i), reg_write, 0);
      check($sformatf("halt_hold%0d_imem_req", i), imem_req, 0);
      #1;
      enable = ~enable;
    end
    toggle_mode = 1'b0;
    enable = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    check("illegal_reset_halted", halted, 0);
    check("illegal_reset_illegal_op", illegal_op, 0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;

    issue(0, 255, 0, 0, halt_rec(16, 0, 0, 1));
    enable = 1'b1;
    wait_end("imem_timeout", 60);
    enable = 1'b0;
    rst_n = 1'b0;
    #1;
    check("timeout_reset_mem_fault", mem_fault, 0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;

    opcode = 6'd12;
    imem_delay = 0;
    dmem_delay = 255;
    enable = 1'b1;
    for (int k = 0; k < 20 && mem_op != MEM_OP_WRITE; k++) @(negedge clk);
    check("midmem_reached_write", mem_op, MEM_OP_WRITE);
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check("midmem_reset_mem_op", mem_op, MEM_OP_NOP);
    check("midmem_reset_alu_src", alu_src, 0);
    check("midmem_reset_imem_req", imem_req, 0);
    check("midmem_reset_instr_done", instr_done, 0);
    enable = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    check("midmem_idle_imem_req", imem_req, 0);
    check("queue_drained", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got no finish expected finish before 100000");
    $fatal(1, "watchdog expired");
  end

endmodule
